// File: rtl/tpu_job_scheduler.sv
// Round-robin job scheduler sharing one TPU core between NUM_REQ requesters.
// Optional WAIT_DONE watchdog with ABORT state: define TPU_SCHED_TIMEOUT_EN.
module tpu_job_scheduler #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned matrixSize     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned ID_W          = $clog2(NUM_REQ),
  localparam int unsigned ROW_W         = $clog2(matrixSize)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               tpu_start,
  input  logic               tpu_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ROW_W-1:0]   rsp_row_idx,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_last,
  output logic               timeout_err
);

`ifdef TPU_SCHED_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, START, WAIT_DONE, DRAIN, ABORT} state_t;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
`else
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, DRAIN} state_t;
`endif

  state_t           state, next_state;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  idx;
  logic             found;
  logic [ROW_W-1:0] row;
  logic             accept;
  logic             beat;

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(last_grant) + 32'(k)) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    busy       = (state != IDLE);
    tpu_start  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_last   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready  = NUM_REQ'(1) << winner;
          next_state = START;
        end
      end
      START: begin
        tpu_start  = 1'b1;
        next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tpu_done) next_state = DRAIN;
`ifdef TPU_SCHED_TIMEOUT_EN
        else if (to_hit) next_state = ABORT;
`endif
      end
      DRAIN: begin
        rsp_valid = 1'b1;
        rsp_last  = (row == ROW_W'(matrixSize - 1));
        if (rsp_ready && rsp_last) next_state = IDLE;
      end
`ifdef TPU_SCHED_TIMEOUT_EN
      ABORT: next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  assign accept      = (state == IDLE) && found;
  assign beat        = rsp_valid && rsp_ready;
  assign rsp_row_idx = row;
  assign rsp_id      = grant_id;

  // Grant ownership, fairness pointer and result row counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      row        <= '0;
    end else begin
      if (accept) grant_id <= winner;
      if (state == WAIT_DONE && tpu_done) row <= '0;
      else if (beat && !rsp_last)         row <= row + ROW_W'(1);
      if (beat && rsp_last) last_grant <= grant_id;
`ifdef TPU_SCHED_TIMEOUT_EN
      if (state == ABORT) last_grant <= grant_id;
`endif
    end
  end

`ifdef TPU_SCHED_TIMEOUT_EN
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT_DONE cycles; error is sticky until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WAIT_DONE) to_cnt <= to_cnt + TO_W'(1);
      else                    to_cnt <= '0;
      if (accept)              timeout_err <= 1'b0;
      else if (state == ABORT) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Directed bench for tpu_job_scheduler: table of jobs plus reset and watchdog sequences.
module tb_tpu_job_scheduler;

  logic       clk;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [0:0] grant_id;
  logic       busy;
  logic       tpu_start;
  logic       tpu_done;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_row_idx;
  logic [0:0] rsp_id;
  logic       rsp_last;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  tpu_job_scheduler #(
    .NUM_REQ        (2),
    .matrixSize     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .tpu_start   (tpu_start),
    .tpu_done    (tpu_done),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_row_idx (rsp_row_idx),
    .rsp_id      (rsp_id),
    .rsp_last    (rsp_last),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] rv;
    int         lat;
    logic [3:0] pat;
    logic       dis;
    int         exp_id;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full job: accept, start pulse, wait lat cycles for done, drain 8 rows.
  task automatic run_job(input logic [1:0] rv, input int lat, input logic [3:0] pat,
                         input logic dis, input int exp_id);
    int beats;
    int cyc;
    req_valid = rv;
    #1;
    check("accept_req_ready", 32'(req_ready), 32'(1) << exp_id);
    tick();
    check("start_pulse", 32'(tpu_start), 32'd1);
    check("grant_id", 32'(grant_id), 32'(exp_id));
    check("start_busy", 32'(busy), 32'd1);
    check("start_req_ready", 32'(req_ready), 32'd0);
    check("start_timeout_clr", 32'(timeout_err), 32'd0);
    tpu_done = dis;
    tick();
    check("start_width", 32'(tpu_start), 32'd0);
    for (int i = 0; i < lat; i++) begin
      tpu_done = 1'b0;
      #1;
      check("wait_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    tpu_done = 1'b1;
    tick();
    tpu_done  = 1'b0;
    req_valid = ~rv;
    beats = 0;
    cyc   = 0;
    while (beats < 8 && cyc < 64) begin
      rsp_ready = pat[cyc % 4];
      #1;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_row_idx", 32'(rsp_row_idx), 32'(beats));
      check("rsp_id", 32'(rsp_id), 32'(exp_id));
      check("rsp_last", 32'(rsp_last), (beats == 7) ? 32'd1 : 32'd0);
      if (rsp_ready) beats++;
      tick();
      cyc++;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check("drain_beats", 32'(beats), 32'd8);
    #1;
    check("end_idle", 32'(busy), 32'd0);
    check("end_rsp_valid", 32'(rsp_valid), 32'd0);
    check("end_timeout", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    vecs[0] = '{rv: 2'b11, lat: 2,  pat: 4'b1111, dis: 1'b0, exp_id: 0};
    vecs[1] = '{rv: 2'b11, lat: 1,  pat: 4'b1111, dis: 1'b0, exp_id: 1};
    vecs[2] = '{rv: 2'b01, lat: 0,  pat: 4'b1111, dis: 1'b0, exp_id: 0};
    vecs[3] = '{rv: 2'b01, lat: 3,  pat: 4'b1111, dis: 1'b0, exp_id: 0};
    vecs[4] = '{rv: 2'b01, lat: 1,  pat: 4'b1111, dis: 1'b0, exp_id: 0};
    vecs[5] = '{rv: 2'b10, lat: 2,  pat: 4'b1001, dis: 1'b0, exp_id: 1};
    vecs[6] = '{rv: 2'b11, lat: 2,  pat: 4'b1111, dis: 1'b1, exp_id: 0};
    vecs[7] = '{rv: 2'b11, lat: 0,  pat: 4'b1001, dis: 1'b1, exp_id: 1};
    vecs[8] = '{rv: 2'b10, lat: 1,  pat: 4'b0110, dis: 1'b0, exp_id: 1};
    vecs[9] = '{rv: 2'b01, lat: 15, pat: 4'b1111, dis: 1'b0, exp_id: 0};

    reset     = 1'b1;
    req_valid = 2'b00;
    tpu_done  = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tpu_start", 32'(tpu_start), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_last", 32'(rsp_last), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // No requests: scheduler stays idle.
    for (int i = 0; i < 3; i++) begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_req_ready", 32'(req_ready), 32'd0);
      tick();
    end

    for (int v = 0; v < 10; v++)
      run_job(vecs[v].rv, vecs[v].lat, vecs[v].pat, vecs[v].dis, vecs[v].exp_id);

    // Reset in the middle of a drain drops the job and restores the pointer.
    req_valid = 2'b11;
    #1;
    check("rstjob_req_ready", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b00;
    tick();
    tpu_done = 1'b1;
    tick();
    tpu_done  = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    rsp_ready = 1'b0;
    #1;
    check("rstjob_row3", 32'(rsp_row_idx), 32'd3);
    check("rstjob_id", 32'(rsp_id), 32'd1);
    reset = 1'b1;
    #1;
    check("rstjob_busy", 32'(busy), 32'd0);
    check("rstjob_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rstjob_row_clr", 32'(rsp_row_idx), 32'd0);
    check("rstjob_grant_clr", 32'(grant_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_job(2'b11, 1, 4'b1111, 1'b0, 0);

`ifdef TPU_SCHED_TIMEOUT_EN
    // Core never answers: abort after 16 WAIT_DONE cycles, sticky error.
    req_valid = 2'b10;
    #1;
    check("to_req_ready", 32'(req_ready), 32'b10);
    tick();
    req_valid = 2'b00;
    check("to_start", 32'(tpu_start), 32'd1);
    tick();
    for (int w = 0; w < 16; w++) begin
      check("to_wait_busy", 32'(busy), 32'd1);
      check("to_wait_rsp", 32'(rsp_valid), 32'd0);
      check("to_wait_err", 32'(timeout_err), 32'd0);
      tick();
    end
    check("to_abort_busy", 32'(busy), 32'd1);
    check("to_abort_rsp", 32'(rsp_valid), 32'd0);
    tick();
    check("to_err_set", 32'(timeout_err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    tick();
    check("to_err_sticky", 32'(timeout_err), 32'd1);
    check("to_no_rsp", 32'(rsp_valid), 32'd0);
    run_job(2'b11, 15, 4'b1111, 1'b0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
